// File: rtl/axi4_stream_pkt_fifo.sv
// Single-clock AXI4-Stream FIFO with packet commit/rewind pointers.
// MODE=0 is cut-through with backpressure; MODE=1 is store-and-forward with drops.
module axi4_stream_pkt_fifo #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TUSER_WIDTH = 1,
  parameter int unsigned TDEST_WIDTH = 1,
  parameter int unsigned TID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned MODE        = 1,
  parameter int unsigned DROP_ON_ERR = 1,
  parameter int unsigned ERR_BIT     = 0,
  parameter int unsigned AFULL_LVL   = (2 ** ADDR_WIDTH) - 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // input stream
  input  logic [TDATA_WIDTH-1:0]   pkt_i_tdata,
  input  logic [TDATA_WIDTH/8-1:0] pkt_i_tstrb,
  input  logic [TDATA_WIDTH/8-1:0] pkt_i_tkeep,
  input  logic                     pkt_i_tlast,
  input  logic [TUSER_WIDTH-1:0]   pkt_i_tuser,
  input  logic [TDEST_WIDTH-1:0]   pkt_i_tdest,
  input  logic [TID_WIDTH-1:0]     pkt_i_tid,
  input  logic                     pkt_i_tvalid,
  output logic                     pkt_i_tready,
  // output stream
  output logic [TDATA_WIDTH-1:0]   pkt_o_tdata,
  output logic [TDATA_WIDTH/8-1:0] pkt_o_tstrb,
  output logic [TDATA_WIDTH/8-1:0] pkt_o_tkeep,
  output logic                     pkt_o_tlast,
  output logic [TUSER_WIDTH-1:0]   pkt_o_tuser,
  output logic [TDEST_WIDTH-1:0]   pkt_o_tdest,
  output logic [TID_WIDTH-1:0]     pkt_o_tid,
  output logic                     pkt_o_tvalid,
  input  logic                     pkt_o_tready,
  // status
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [ADDR_WIDTH:0]      used_words_o,
  output logic [ADDR_WIDTH:0]      pkts_amount_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned StrbW = TDATA_WIDTH / 8;
  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned WordW = TDATA_WIDTH + 2 * StrbW + 1 + TUSER_WIDTH + TDEST_WIDTH
                                  + TID_WIDTH;
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);

  typedef enum logic [0:0] {StWr, StDrop} state_e;

  logic [WordW-1:0] mem_q [Depth];
  logic [WordW-1:0] wdata;
  logic [WordW-1:0] rdata_q;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] pkts_q, pkts_d;
  logic            out_valid_q, out_valid_d;
  logic            drop_q, drop_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;

  logic [PtrW-1:0] used;
  logic            full;
  logic            accept;
  logic            wr_en;
  logic            commit;
  logic            drop_pkt;
  logic            err_flag;
  logic            fetch;
  logic            out_hs;
  logic            pkt_done;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PtrW'(Depth));
  assign accept   = pkt_i_tvalid && pkt_i_tready;
  assign err_flag = (DROP_ON_ERR != 0) && pkt_i_tuser[ERR_BIT];
  assign wdata    = {pkt_i_tuser, pkt_i_tdest, pkt_i_tid, pkt_i_tlast, pkt_i_tkeep, pkt_i_tstrb,
                     pkt_i_tdata};

  assign pkt_i_tready = (MODE == 0) ? !full : 1'b1;

  // Fetch only committed words, so a rewind can never reclaim a word already read.
  assign out_hs   = out_valid_q && pkt_o_tready;
  assign fetch    = (commit_ptr_q != rd_ptr_q) && (!out_valid_q || pkt_o_tready);
  assign pkt_done = out_hs && pkt_o_tlast;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_cnt_d   = drop_cnt_q;
    drop_d       = 1'b0;
    wr_en        = 1'b0;
    commit       = 1'b0;
    drop_pkt     = 1'b0;

    if (accept) begin
      if (MODE == 0) begin
        if (!full) begin
          wr_en        = 1'b1;
          wr_ptr_d     = wr_ptr_q + PtrOne;
          commit_ptr_d = wr_ptr_q + PtrOne;
          commit       = pkt_i_tlast;
        end
      end else begin
        unique case (state_q)
          StWr: begin
            if (full) begin
              wr_ptr_d = commit_ptr_q;
              if (pkt_i_tlast) begin
                drop_pkt = 1'b1;
              end else begin
                state_d = StDrop;
              end
            end else if (pkt_i_tlast) begin
              wr_en = 1'b1;
              if (err_flag) begin
                wr_ptr_d = commit_ptr_q;
                drop_pkt = 1'b1;
              end else begin
                wr_ptr_d     = wr_ptr_q + PtrOne;
                commit_ptr_d = wr_ptr_q + PtrOne;
                commit       = 1'b1;
              end
            end else begin
              wr_en = 1'b1;
              // A non-last word landing in the final slot means the packet cannot fit.
              if (used == PtrW'(Depth - 1)) begin
                wr_ptr_d = commit_ptr_q;
                state_d  = StDrop;
              end else begin
                wr_ptr_d = wr_ptr_q + PtrOne;
              end
            end
          end
          StDrop: begin
            if (pkt_i_tlast) begin
              drop_pkt = 1'b1;
              state_d  = StWr;
            end
          end
          default: state_d = StWr;
        endcase
      end
    end

    if (drop_pkt) begin
      drop_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    rd_ptr_d    = fetch ? rd_ptr_q + PtrOne : rd_ptr_q;
    out_valid_d = out_valid_q;
    if (fetch) begin
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    pkts_d = pkts_q;
    if (commit && !pkt_done) begin
      pkts_d = pkts_q + PtrOne;
    end else if (!commit && pkt_done) begin
      pkts_d = pkts_q - PtrOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StWr;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkts_q       <= '0;
      out_valid_q  <= 1'b0;
      drop_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkts_q       <= pkts_d;
      out_valid_q  <= out_valid_d;
      drop_q       <= drop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage and its read register carry no reset; the read register doubles as output stage.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdata;
    end
    if (fetch) begin
      rdata_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign {pkt_o_tuser, pkt_o_tdest, pkt_o_tid, pkt_o_tlast, pkt_o_tkeep, pkt_o_tstrb,
          pkt_o_tdata} = rdata_q;

  assign pkt_o_tvalid  = out_valid_q;
  assign empty_o       = !out_valid_q;
  assign full_o        = full;
  assign almost_full_o = (used >= PtrW'(AFULL_LVL));
  assign used_words_o  = used;
  assign pkts_amount_o = pkts_q;
  assign drop_o        = drop_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_axi4_stream_pkt_fifo.sv
// Bench for axi4_stream_pkt_fifo: one cut-through and one store-and-forward instance,
// word scoreboard fed from accepted input, drained at the output handshake.
module tb_axi4_stream_pkt_fifo;

  localparam int unsigned Depth = 8;

  // {last, user, dest, id, strb[3:0], keep[3:0], data[31:0]}
  typedef logic [43:0] word_t;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] i_tdata  [2];
  logic [3:0]  i_tstrb  [2];
  logic [3:0]  i_tkeep  [2];
  logic        i_tlast  [2];
  logic        i_tuser  [2];
  logic        i_tdest  [2];
  logic        i_tid    [2];
  logic        i_tvalid [2];
  logic        i_tready [2];
  logic [31:0] o_tdata  [2];
  logic [3:0]  o_tstrb  [2];
  logic [3:0]  o_tkeep  [2];
  logic        o_tlast  [2];
  logic        o_tuser  [2];
  logic        o_tdest  [2];
  logic        o_tid    [2];
  logic        o_tvalid [2];
  logic        o_tready [2];
  logic        full     [2];
  logic        afull    [2];
  logic        empty    [2];
  logic        drop     [2];
  logic [3:0]  used     [2];
  logic [3:0]  pkts     [2];
  logic [15:0] dcnt     [2];

  axi4_stream_pkt_fifo #(.MODE(0), .DROP_ON_ERR(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i),
    .pkt_i_tdata(i_tdata[0]), .pkt_i_tstrb(i_tstrb[0]), .pkt_i_tkeep(i_tkeep[0]),
    .pkt_i_tlast(i_tlast[0]), .pkt_i_tuser(i_tuser[0]), .pkt_i_tdest(i_tdest[0]),
    .pkt_i_tid(i_tid[0]), .pkt_i_tvalid(i_tvalid[0]), .pkt_i_tready(i_tready[0]),
    .pkt_o_tdata(o_tdata[0]), .pkt_o_tstrb(o_tstrb[0]), .pkt_o_tkeep(o_tkeep[0]),
    .pkt_o_tlast(o_tlast[0]), .pkt_o_tuser(o_tuser[0]), .pkt_o_tdest(o_tdest[0]),
    .pkt_o_tid(o_tid[0]), .pkt_o_tvalid(o_tvalid[0]), .pkt_o_tready(o_tready[0]),
    .full_o(full[0]), .almost_full_o(afull[0]), .empty_o(empty[0]), .drop_o(drop[0]),
    .used_words_o(used[0]), .pkts_amount_o(pkts[0]), .drop_cnt_o(dcnt[0])
  );

  axi4_stream_pkt_fifo #(.MODE(1), .DROP_ON_ERR(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i),
    .pkt_i_tdata(i_tdata[1]), .pkt_i_tstrb(i_tstrb[1]), .pkt_i_tkeep(i_tkeep[1]),
    .pkt_i_tlast(i_tlast[1]), .pkt_i_tuser(i_tuser[1]), .pkt_i_tdest(i_tdest[1]),
    .pkt_i_tid(i_tid[1]), .pkt_i_tvalid(i_tvalid[1]), .pkt_i_tready(i_tready[1]),
    .pkt_o_tdata(o_tdata[1]), .pkt_o_tstrb(o_tstrb[1]), .pkt_o_tkeep(o_tkeep[1]),
    .pkt_o_tlast(o_tlast[1]), .pkt_o_tuser(o_tuser[1]), .pkt_o_tdest(o_tdest[1]),
    .pkt_o_tid(o_tid[1]), .pkt_o_tvalid(o_tvalid[1]), .pkt_o_tready(o_tready[1]),
    .full_o(full[1]), .almost_full_o(afull[1]), .empty_o(empty[1]), .drop_o(drop[1]),
    .used_words_o(used[1]), .pkts_amount_o(pkts[1]), .drop_cnt_o(dcnt[1])
  );

  int    checks = 0;
  int    errors = 0;
  int    pkt_id = 1;
  int    sent        [2];
  int    delivered   [2];
  int    drop_pulses [2];
  int    used_over   [2];
  word_t exp_q0 [$];
  word_t exp_q1 [$];
  word_t stage1 [$];
  logic  prev_stall [2];
  word_t prev_word  [2];
  word_t mon_got;
  word_t mon_exp;
  bit    mon_have;

  function automatic word_t in_word(input int m);
    return {i_tlast[m], i_tuser[m], i_tdest[m], i_tid[m], i_tstrb[m], i_tkeep[m], i_tdata[m]};
  endfunction

  function automatic word_t out_word(input int m);
    return {o_tlast[m], o_tuser[m], o_tdest[m], o_tid[m], o_tstrb[m], o_tkeep[m], o_tdata[m]};
  endfunction

  // Input side: cut-through expects every word; store-and-forward expects only packets
  // that are clean and short enough to ever fit.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (i_tvalid[0] && i_tready[0]) exp_q0.push_back(in_word(0));
      if (i_tvalid[1] && i_tready[1]) begin
        stage1.push_back(in_word(1));
        if (i_tlast[1]) begin
          if (!i_tuser[1] && stage1.size() <= Depth) begin
            foreach (stage1[k]) exp_q1.push_back(stage1[k]);
          end
          stage1.delete();
        end
      end
    end
  end

  // Output side: scoreboard compare, stall stability and status invariants.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        mon_got = out_word(m);
        if (drop[m]) drop_pulses[m]++;
        if (used[m] > 4'(Depth)) used_over[m]++;
        if (prev_stall[m]) begin
          checks++;
          if (!o_tvalid[m] || mon_got !== prev_word[m]) begin
            errors++;
            $display("FAIL stall_hold m%0d: got valid=%b word=%h, required valid=1 word=%h",
                     m, o_tvalid[m], mon_got, prev_word[m]);
          end
        end
        prev_stall[m] = o_tvalid[m] && !o_tready[m];
        prev_word[m]  = mon_got;
        if (o_tvalid[m] && o_tready[m]) begin
          if (mon_got[43]) delivered[m]++;
          mon_have = 1'b0;
          if (m == 0) begin
            if (exp_q0.size() != 0) begin
              mon_exp  = exp_q0.pop_front();
              mon_have = 1'b1;
            end
          end else begin
            // Earlier expected packets with another id were lost to overflow.
            while (exp_q1.size() != 0 && exp_q1[0][31:16] != mon_got[31:16]) begin
              void'(exp_q1.pop_front());
            end
            if (exp_q1.size() != 0) begin
              mon_exp  = exp_q1.pop_front();
              mon_have = 1'b1;
            end
          end
          checks++;
          if (!mon_have) begin
            errors++;
            $display("FAIL out_word m%0d: got %h, required no output", m, mon_got);
          end else if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL out_word m%0d: got %h, required %h", m, mon_got, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_i = 1'b1;
    for (int m = 0; m < 2; m++) begin
      i_tvalid[m] = 1'b0; i_tlast[m] = 1'b0; i_tuser[m] = 1'b0; i_tdata[m] = '0;
      i_tkeep[m]  = '0;   i_tstrb[m] = '0;   i_tid[m]   = 1'b0; i_tdest[m] = 1'b0;
      o_tready[m] = 1'b1;
      sent[m] = 0; delivered[m] = 0; drop_pulses[m] = 0; used_over[m] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
    stage1.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic send_pkt(input int m, input int len, input bit err, input int gap_max);
    int guard;
    for (int w = 0; w < len; w++) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      i_tvalid[m] = 1'b1;
      i_tdata[m]  = {pkt_id[15:0], w[15:0]};
      i_tkeep[m]  = 4'($urandom);
      i_tstrb[m]  = i_tkeep[m];
      i_tlast[m]  = (w == len - 1);
      i_tuser[m]  = err && (w == len - 1);
      i_tid[m]    = pkt_id[0];
      i_tdest[m]  = w[0];
      guard = 0;
      while (!i_tready[m] && guard < 5000) begin @(posedge clk); #1; guard++; end
      if (!i_tready[m]) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout m%0d: got tready=0, required 1", m);
      end
      @(posedge clk);
      #1;
      i_tvalid[m] = 1'b0;
    end
    pkt_id++;
    sent[m]++;
  endtask

  task automatic wait_drain(input int m);
    int guard = 0;
    o_tready[m] = 1'b1;
    while ((o_tvalid[m] || used[m] != 0) && guard < 3000) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (o_tvalid[m] || used[m] != 0) begin
      errors++;
      $display("FAIL drain m%0d: got valid=%b used=%0d, required valid=0 used=0",
               m, o_tvalid[m], used[m]);
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({o_tvalid[m], empty[m], full[m], afull[m], drop[m], i_tready[m], used[m], pkts[m],
           dcnt[m]} !== {6'b010001, 4'd0, 4'd0, 16'd0}) begin
        errors++;
        $display("FAIL reset_state m%0d: got v=%b e=%b f=%b af=%b d=%b rdy=%b used=%0d pk=%0d dc=%0d, required v=0 e=1 f=0 af=0 d=0 rdy=1 used=0 pk=0 dc=0",
                 m, o_tvalid[m], empty[m], full[m], afull[m], drop[m], i_tready[m], used[m],
                 pkts[m], dcnt[m]);
      end
    end
    // Asynchronous reset with words in flight empties the FIFO without a clock edge.
    o_tready[0] = 1'b0;
    send_pkt(0, 3, 1'b0, 0);
    rst_i = 1'b1;
    #1;
    checks++;
    if (used[0] !== 4'd0 || o_tvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got used=%0d valid=%b, required used=0 valid=0",
               used[0], o_tvalid[0]);
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    send_pkt(1, 3, 1'b0, 0);
    checks++;
    if (o_tvalid[1] !== 1'b0 || pkts[1] !== 4'd1) begin
      errors++;
      $display("FAIL latency_commit: got valid=%b pkts=%0d, required valid=0 pkts=1",
               o_tvalid[1], pkts[1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (o_tvalid[1] !== 1'b1) begin
      errors++;
      $display("FAIL latency_valid: got valid=%b, required 1", o_tvalid[1]);
    end
    wait_drain(1);
    checks++;
    if (pkts[1] !== 4'd0 || delivered[1] != 1) begin
      errors++;
      $display("FAIL latency_done: got pkts=%0d delivered=%0d, required 0 and 1",
               pkts[1], delivered[1]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    o_tready[1] = 1'b0;
    send_pkt(1, 10, 1'b0, 0);
    send_pkt(1, 2, 1'b0, 0);
    checks++;
    if (used[1] !== 4'd2 || pkts[1] !== 4'd1 || dcnt[1] !== 16'd1) begin
      errors++;
      $display("FAIL overflow_state: got used=%0d pkts=%0d dcnt=%0d, required 2 1 1",
               used[1], pkts[1], dcnt[1]);
    end
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (drop_pulses[1] != 1) begin
      errors++;
      $display("FAIL overflow_pulse: got %0d drop pulses, required 1", drop_pulses[1]);
    end
    wait_drain(1);
    checks++;
    if (delivered[1] != 1 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL overflow_deliver: got delivered=%0d pending=%0d, required 1 and 0",
               delivered[1], exp_q1.size());
    end
  endtask

  task automatic test_err_drop();
    do_reset();
    send_pkt(1, 4, 1'b1, 0);
    checks++;
    if (used[1] !== 4'd0 || pkts[1] !== 4'd0 || dcnt[1] !== 16'd1) begin
      errors++;
      $display("FAIL err_rewind: got used=%0d pkts=%0d dcnt=%0d, required 0 0 1",
               used[1], pkts[1], dcnt[1]);
    end
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (o_tvalid[1] !== 1'b0 || delivered[1] != 0 || drop_pulses[1] != 1) begin
      errors++;
      $display("FAIL err_output: got valid=%b delivered=%0d pulses=%0d, required 0 0 1",
               o_tvalid[1], delivered[1], drop_pulses[1]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    o_tready[0] = 1'b0;
    fork
      send_pkt(0, 10, 1'b0, 0);
      begin
        repeat (14) begin @(posedge clk); #1; end
        checks++;
        if (full[0] !== 1'b1 || afull[0] !== 1'b1 || i_tready[0] !== 1'b0 ||
            used[0] !== 4'd8) begin
          errors++;
          $display("FAIL bp_full: got full=%b afull=%b tready=%b used=%0d, required 1 1 0 8",
                   full[0], afull[0], i_tready[0], used[0]);
        end
        o_tready[0] = 1'b1;
      end
    join
    wait_drain(0);
    checks++;
    if (delivered[0] != 1 || dcnt[0] !== 16'd0 || exp_q0.size() != 0) begin
      errors++;
      $display("FAIL bp_deliver: got delivered=%0d dcnt=%0d pending=%0d, required 1 0 0",
               delivered[0], dcnt[0], exp_q0.size());
    end
  endtask

  task automatic test_drain_overflow();
    do_reset();
    o_tready[1] = 1'b0;
    send_pkt(1, 6, 1'b0, 0);
    o_tready[1] = 1'b1;
    send_pkt(1, 10, 1'b0, 0);
    wait_drain(1);
    checks++;
    if (delivered[1] != 1 || dcnt[1] !== 16'd1 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain_overflow: got delivered=%0d dcnt=%0d pending=%0d, required 1 1 0",
               delivered[1], dcnt[1], exp_q1.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int p = 0; p < 4; p++) send_pkt(1, 2, 1'b0, 0);
    wait_drain(1);
    checks++;
    if (delivered[1] != 4 || dcnt[1] !== 16'd0) begin
      errors++;
      $display("FAIL back_to_back: got delivered=%0d dcnt=%0d, required 4 0",
               delivered[1], dcnt[1]);
    end
  endtask

  task automatic test_random(input int m, input int npkts);
    bit done = 1'b0;
    do_reset();
    fork
      begin
        for (int p = 0; p < npkts; p++) begin
          send_pkt(m, $urandom_range(1, 10), (m == 1) && ($urandom_range(0, 7) == 0), 2);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          o_tready[m] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wait_drain(m);
    checks++;
    if (used_over[m] != 0 || pkts[m] !== 4'd0) begin
      errors++;
      $display("FAIL rand_status m%0d: got used_over=%0d pkts=%0d, required 0 0",
               m, used_over[m], pkts[m]);
    end
    checks++;
    if (drop_pulses[m] != int'(dcnt[m])) begin
      errors++;
      $display("FAIL rand_pulses m%0d: got pulses=%0d, required %0d", m, drop_pulses[m],
               dcnt[m]);
    end
    checks++;
    if (m == 0) begin
      if (delivered[0] != sent[0] || dcnt[0] !== 16'd0 || exp_q0.size() != 0) begin
        errors++;
        $display("FAIL rand_ct: got delivered=%0d dcnt=%0d pending=%0d, required %0d 0 0",
                 delivered[0], dcnt[0], exp_q0.size(), sent[0]);
      end
    end else begin
      if (int'(dcnt[1]) != sent[1] - delivered[1] || delivered[1] == 0) begin
        errors++;
        $display("FAIL rand_sf: got dcnt=%0d delivered=%0d, required dcnt=%0d delivered>0",
                 dcnt[1], delivered[1], sent[1] - delivered[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_err_drop();
    test_backpressure();
    test_drain_overflow();
    test_back_to_back();
    test_random(0, 1000);
    test_random(1, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
